// File: rtl/io_port_pkg.sv
// Shared constants for the I/O port bank.
//   PORT_*  : port addresses decoded from port_id
//   ST_*    : bit positions inside the status word read from PORT_STATUS
package io_port_pkg;

    localparam logic [2:0] PORT_OUT0    = 3'd0;
    localparam logic [2:0] PORT_OUT1    = 3'd1;
    localparam logic [2:0] PORT_OUT2    = 3'd2;
    localparam logic [2:0] PORT_GPIO_IN = 3'd3;
    localparam logic [2:0] PORT_TX      = 3'd4;
    localparam logic [2:0] PORT_RX      = 3'd5;
    localparam logic [2:0] PORT_STATUS  = 3'd6;
    localparam logic [2:0] PORT_SCRATCH = 3'd7;

    localparam int unsigned ST_TX_FULL     = 0;
    localparam int unsigned ST_TX_EMPTY    = 1;
    localparam int unsigned ST_RX_NONEMPTY = 2;
    localparam int unsigned ST_OVERFLOW    = 3;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, single clock.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   push, push_data     : write request and data (ignored when full)
//   pop                 : read request (ignored when empty)
//   head                : oldest entry, forced to 0 while empty
//   full, empty, count  : occupancy, all from pre-edge state
module sync_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Masked so a drained FIFO presents 0 rather than stale storage.
    assign head    = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped I/O stage behind a command-controlled device.
// Ports:
//   clock, reset                 : system clock, synchronous active-high reset
//   port_id/port_write/port_read : address and one-cycle strobes from the device
//   wr_data / rd_data            : write data in, read data back (0 when not reading)
//   gpio_out                     : {port2, port1, port0} output latches
//   gpio_in                      : asynchronous input, two-flop synchronised
//   tx_data/tx_valid/tx_ready    : outbound stream from the TX FIFO
//   rx_data/rx_valid/rx_ready    : inbound stream into the RX FIFO
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  port_id,
    input  logic        port_write,
    input  logic        port_read,
    input  logic [3:0]  wr_data,
    output logic [3:0]  rd_data,
    output logic [11:0] gpio_out,
    input  logic [3:0]  gpio_in,
    output logic [3:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [3:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [11:0]   gpio_q;
    logic [3:0]    scratch_q;
    logic [3:0]    sync1_q, sync2_q;
    logic          overflow_q;

    logic          tx_push, tx_pop, tx_full, tx_empty, tx_drop;
    logic [CW-1:0] tx_count;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [3:0]    rx_head;
    logic [CW-1:0] rx_count;
    logic          ovf_clear;
    logic [3:0]    status;

    assign tx_push   = port_write && (port_id == PORT_TX);
    // Fullness is the pre-edge value, so a concurrent tx pop never rescues the push.
    assign tx_drop   = tx_push && tx_full;
    assign tx_pop    = tx_valid && tx_ready;
    assign tx_valid  = !tx_empty;

    assign rx_ready  = !rx_full && !reset;
    assign rx_push   = rx_valid && rx_ready;
    assign rx_pop    = port_read && (port_id == PORT_RX);

    assign ovf_clear = port_write && (port_id == PORT_STATUS) && wr_data[3];
    assign gpio_out  = gpio_q;

    sync_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push),
        .push_data (wr_data),
        .pop       (tx_pop),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    sync_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            gpio_q     <= '0;
            scratch_q  <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            // A drop in the same cycle as a clear wins.
            if (tx_drop) begin
                overflow_q <= 1'b1;
            end else if (ovf_clear) begin
                overflow_q <= 1'b0;
            end
            if (port_write) begin
                case (port_id)
                    PORT_OUT0:    gpio_q[3:0]   <= wr_data;
                    PORT_OUT1:    gpio_q[7:4]   <= wr_data;
                    PORT_OUT2:    gpio_q[11:8]  <= wr_data;
                    PORT_SCRATCH: scratch_q     <= wr_data;
                    default:      ;
                endcase
            end
        end
    end

    always_comb begin
        status                 = '0;
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_EMPTY]    = (tx_count == '0);
        status[ST_RX_NONEMPTY] = (rx_count != '0);
        status[ST_OVERFLOW]    = overflow_q;
    end

    always_comb begin
        rd_data = '0;
        if (port_read) begin
            case (port_id)
                PORT_OUT0:    rd_data = gpio_q[3:0];
                PORT_OUT1:    rd_data = gpio_q[7:4];
                PORT_OUT2:    rd_data = gpio_q[11:8];
                PORT_GPIO_IN: rd_data = sync2_q;
                PORT_TX:      rd_data = '0;
                PORT_RX:      rd_data = rx_empty ? '0 : rx_head;
                PORT_STATUS:  rd_data = status;
                PORT_SCRATCH: rd_data = scratch_q;
                default:      rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// Bench for io_port_bank: queue-based reference model checked every cycle,
// plus directed vectors with literal expected values.
module tb_io_port_bank;

    localparam int unsigned D = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  port_id;
    logic        port_write, port_read;
    logic [3:0]  wr_data, rd_data;
    logic [11:0] gpio_out;
    logic [3:0]  gpio_in, tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clock = ~clock;

    io_port_bank #(.FIFO_DEPTH(D)) dut (
        .clock      (clock),
        .reset      (reset),
        .port_id    (port_id),
        .port_write (port_write),
        .port_read  (port_read),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .gpio_out   (gpio_out),
        .gpio_in    (gpio_in),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
    );

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model
    logic [3:0] m_lat [3];
    logic [3:0] m_scratch, m_s1, m_s2;
    bit         m_ovf;
    logic [3:0] tx_q [$];
    logic [3:0] rx_q [$];
    bit         model_valid = 0;

    function automatic logic [3:0] m_status();
        return {m_ovf, rx_q.size() != 0, tx_q.size() == 0, tx_q.size() == D};
    endfunction

    function automatic logic [3:0] m_rd();
        if (!port_read) return 4'h0;
        case (port_id)
            3'd0, 3'd1, 3'd2: return m_lat[port_id];
            3'd3:    return m_s2;
            3'd5:    return (rx_q.size() != 0) ? rx_q[0] : 4'h0;
            3'd6:    return m_status();
            3'd7:    return m_scratch;
            default: return 4'h0;
        endcase
    endfunction

    always @(posedge clock) begin
        bit tx_full_pre, rx_full_pre, drop;
        if (reset) begin
            for (int i = 0; i < 3; i++) m_lat[i] = 4'h0;
            m_scratch = 4'h0;
            m_s1 = 4'h0;
            m_s2 = 4'h0;
            m_ovf = 0;
            tx_q.delete();
            rx_q.delete();
            model_valid = 1;
        end else if (model_valid) begin
            tx_full_pre = (tx_q.size() == D);
            rx_full_pre = (rx_q.size() == D);
            drop = 0;
            if (port_read && port_id == 3'd5 && rx_q.size() != 0) void'(rx_q.pop_front());
            if (rx_valid && !rx_full_pre) rx_q.push_back(rx_data);
            if (tx_ready && tx_q.size() != 0) void'(tx_q.pop_front());
            if (port_write) begin
                case (port_id)
                    3'd0, 3'd1, 3'd2: m_lat[port_id] = wr_data;
                    3'd4: if (tx_full_pre) drop = 1; else tx_q.push_back(wr_data);
                    3'd7: m_scratch = wr_data;
                    default: ;
                endcase
            end
            if (drop) m_ovf = 1;
            else if (port_write && port_id == 3'd6 && wr_data[3]) m_ovf = 0;
            m_s2 = m_s1;
            m_s1 = gpio_in;
        end
    end

    always @(negedge clock) begin
        if (model_valid) begin
            check("gpio_out", gpio_out, {m_lat[2], m_lat[1], m_lat[0]});
            check("tx_valid", 12'(tx_valid), 12'(tx_q.size() != 0));
            check("tx_data", 12'(tx_data), 12'((tx_q.size() != 0) ? tx_q[0] : 4'h0));
            check("rx_ready", 12'(rx_ready), 12'(!reset && rx_q.size() < D));
            check("rd_data", 12'(rd_data), 12'(m_rd()));
        end
    end

    // Stimulus: inputs change 1 time unit after the falling edge.
    task automatic drive(input bit w, input bit r, input logic [2:0] id, input logic [3:0] d);
        @(negedge clock);
        #1;
        port_write = w;
        port_read  = r;
        port_id    = id;
        wr_data    = d;
    endtask

    logic [3:0] rxv [4];

    initial begin
        rxv = '{4'h6, 4'h7, 4'h8, 4'h9};
        reset = 1; port_id = 0; port_write = 0; port_read = 0; wr_data = 0;
        gpio_in = 0; tx_ready = 0; rx_data = 0; rx_valid = 0;
        repeat (2) @(posedge clock);
        @(negedge clock); #1; reset = 0;

        // Reset and latches
        drive(1, 0, 3'd0, 4'hA);
        drive(1, 0, 3'd2, 4'h5);
        drive(1, 0, 3'd7, 4'hF);
        drive(0, 1, 3'd0, 4'h0); #1;
        check("lit_gpio_50A", gpio_out, 12'h50A);
        check("lit_rd_p0", 12'(rd_data), 12'hA);
        drive(0, 1, 3'd2, 4'h0); #1; check("lit_rd_p2", 12'(rd_data), 12'h5);
        drive(0, 1, 3'd7, 4'h0); #1; check("lit_rd_p7", 12'(rd_data), 12'hF);
        drive(0, 1, 3'd6, 4'h0); #1; check("lit_status_idle", 12'(rd_data), 12'h2);

        // TX fill, overflow and drain
        for (int i = 1; i <= 4; i++) drive(1, 0, 3'd4, 4'(i));
        drive(0, 1, 3'd6, 4'h0); #1; check("lit_status_txfull", 12'(rd_data), 12'h1);
        drive(1, 0, 3'd4, 4'h5);
        drive(0, 1, 3'd6, 4'h0); #1; check("lit_status_ovf", 12'(rd_data), 12'h9);
        drive(0, 0, 3'd0, 4'h0); tx_ready = 1; #1;
        for (int k = 1; k <= 4; k++) begin
            check("lit_tx_seq", 12'(tx_data), 12'(k));
            drive(0, 0, 3'd0, 4'h0); #1;
        end
        check("lit_tx_drained", 12'(tx_valid), 12'h0);
        tx_ready = 0;
        drive(1, 0, 3'd6, 4'h8);
        drive(0, 1, 3'd6, 4'h0); #1; check("lit_ovf_cleared", 12'(rd_data), 12'h2);

        // RX fill, back-pressure and drain
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 3'd0, 4'h0); rx_valid = 1; rx_data = rxv[i]; #1;
            check("lit_rx_ready_fill", 12'(rx_ready), 12'h1);
        end
        drive(0, 0, 3'd0, 4'h0); rx_data = 4'hB; #1;
        check("lit_rx_ready_full", 12'(rx_ready), 12'h0);
        drive(0, 1, 3'd5, 4'h0); #1; check("lit_rx_pop6", 12'(rd_data), 12'h6);
        drive(0, 1, 3'd5, 4'h0); #1; check("lit_rx_pop7", 12'(rd_data), 12'h7);
        check("lit_rx_ready_again", 12'(rx_ready), 12'h1);
        drive(0, 1, 3'd5, 4'h0); rx_valid = 0; #1; check("lit_rx_pop8", 12'(rd_data), 12'h8);
        drive(0, 1, 3'd5, 4'h0); #1; check("lit_rx_pop9", 12'(rd_data), 12'h9);
        drive(0, 1, 3'd5, 4'h0); #1; check("lit_rx_popB", 12'(rd_data), 12'hB);
        drive(0, 1, 3'd5, 4'h0); #1; check("lit_rx_empty", 12'(rd_data), 12'h0);

        // Push into a full TX FIFO on the same edge as a pop: dropped
        for (int i = 0; i < 4; i++) drive(1, 0, 3'd4, 4'(10 + i));
        drive(1, 0, 3'd4, 4'hE); tx_ready = 1;
        drive(0, 1, 3'd6, 4'h0); tx_ready = 0; #1;
        check("lit_status_drop", 12'(rd_data), 12'h8);
        check("lit_tx_head_B", 12'(tx_data), 12'hB);
        drive(1, 0, 3'd6, 4'h7);
        drive(0, 1, 3'd6, 4'h0); #1; check("lit_ovf_kept", 12'(rd_data), 12'h8);

        // RX push and pop on the same edge
        drive(0, 0, 3'd0, 4'h0); rx_valid = 1; rx_data = 4'h3;
        drive(0, 1, 3'd5, 4'h0); rx_data = 4'h4; #1; check("lit_rx_pp3", 12'(rd_data), 12'h3);
        drive(0, 1, 3'd5, 4'h0); rx_valid = 0; #1; check("lit_rx_pp4", 12'(rd_data), 12'h4);
        drive(0, 1, 3'd5, 4'h0); #1; check("lit_rx_pp_empty", 12'(rd_data), 12'h0);

        // Write and read strobes together
        drive(1, 1, 3'd7, 4'h6); #1; check("lit_rw_old", 12'(rd_data), 12'hF);
        drive(0, 1, 3'd7, 4'h0); #1; check("lit_rw_new", 12'(rd_data), 12'h6);

        // Input synchroniser
        drive(0, 1, 3'd3, 4'h0); gpio_in = 4'h3; #1; check("lit_sync_0", 12'(rd_data), 12'h0);
        drive(0, 1, 3'd3, 4'h0); #1; check("lit_sync_1", 12'(rd_data), 12'h0);
        drive(0, 1, 3'd3, 4'h0); #1; check("lit_sync_2", 12'(rd_data), 12'h3);

        // Reset with both FIFOs partly full
        drive(0, 0, 3'd0, 4'h0); rx_valid = 1; rx_data = 4'h1; tx_ready = 1;
        drive(0, 0, 3'd0, 4'h0); rx_data = 4'h2; tx_ready = 0;
        drive(0, 0, 3'd0, 4'h0); rx_valid = 0; #1;
        check("lit_pre_reset_status", 12'(tx_valid), 12'h1);
        drive(0, 0, 3'd0, 4'h0); reset = 1; #1;
        check("lit_rx_ready_in_reset", 12'(rx_ready), 12'h0);
        drive(0, 1, 3'd6, 4'h0); reset = 0; #1;
        check("lit_rst_tx_valid", 12'(tx_valid), 12'h0);
        check("lit_rst_status", 12'(rd_data), 12'h2);
        check("lit_rst_gpio", gpio_out, 12'h000);
        check("lit_rst_rx_ready", 12'(rx_ready), 12'h1);
        drive(0, 1, 3'd7, 4'h0); #1; check("lit_rst_scratch", 12'(rd_data), 12'h0);
        drive(0, 0, 3'd0, 4'h0);
        @(negedge clock); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Memory-mapped I/O stage directly downstream of the command-controlled device. It decodes the device's `port_id` / `port_write` / `port_read` strobes and its 4-bit result bus, and returns read data to the device's `data_in`. Behind the decoder sit:
- three output latches, a synchronised input port and a scratch register;
- a transmit FIFO and a receive FIFO, each with a valid/ready stream to the outside world.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: entries per FIFO; power of two, ≥ 2.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `port_id`  in  3  port address from the device.
- `port_write`  in  1  write strobe, one cycle per write.
- `port_read`  in  1  read strobe, one cycle per read.
- `wr_data`  in  4  write data (the device's result bus).
- `rd_data`  out  4  read data to the device's `data_in`.
- `gpio_out`  out  12  latches {port2, port1, port0}.
- `gpio_in`  in  4  asynchronous external input.
- `tx_data`  out  4  head of TX FIFO.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_ready`  in  1  external consumer accepts `tx_data`.
- `rx_data`  in  4  external producer data.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  RX FIFO can accept.

## Operation
Port map:
- 0, 1, 2: output latch.
  - Write loads `wr_data` into `gpio_out[4n+3:4n]`.
  - Read returns the latch value.
- 3: `gpio_in` after a two-flop synchroniser. Read-only; writes ignored.
- 4: TX FIFO.
  - Write pushes `wr_data`.
  - Read returns 0.
- 5: RX FIFO.
  - Read returns the head entry and pops it.
  - Writes ignored.
- 6: status, read returns:
  - bit0 = tx_full;
  - bit1 = tx_empty;
  - bit2 = rx_nonempty;
  - bit3 = overflow (sticky).
  - A write with `wr_data[3]=1` clears overflow.
- 7: scratch register, read/write.

Read data:
- `rd_data` is combinational from registered state when `port_read=1`, else 0.
- A read on port 5 with the RX FIFO empty returns 0 and changes nothing.

FIFO push/pop rules:
- TX push when full: data is dropped and overflow is set. Fullness is judged on the pre-edge count, so a same-cycle `tx_ready` pop does not rescue the push.
- `tx_valid` = !tx_empty; `tx_data` = TX head. A transfer occurs on an edge with `tx_valid & tx_ready`.
- `rx_ready` = !rx_full. A push occurs on `rx_valid & rx_ready`, so external data is never dropped.

Overflow flag:
- Set by a TX drop.
- Clearing in the same cycle as a new drop leaves overflow=1.

Strobe rules:
- `port_write` and `port_read` high together: both are performed (e.g. write port 4 while popping port 5).
- Simultaneous push and pop on one FIFO that is neither full nor empty: count unchanged, both pointers advance.
- Pointers wrap modulo `FIFO_DEPTH`. Count width is clog2(`FIFO_DEPTH`)+1.

## Timing
Reset:
- `reset` high at an edge clears latches, scratch, synchroniser, overflow and both FIFO pointers/counts.
- Reset values: `gpio_out`=0, `tx_valid`=0, `tx_data`=0, `rd_data`=0.
- `rx_ready`=0 while `reset` is high; it is 1 from the first cycle after release.
- Reset mid-transfer discards all FIFO contents.

Latencies:
- Write to latch or scratch: visible on `gpio_out` / readback one cycle after the strobe edge.
- TX push: `tx_valid` rises the cycle after the push edge.
- RX push: `rx_nonempty` is readable the cycle after the push edge.
- `gpio_in` change: visible on port 3 two edges later.
- Pop/push effects on status are visible the cycle after the edge.

## Structure
- Package `io_port_pkg` holds:
  - port address constants `PORT_OUT0..PORT_SCRATCH` (0–7);
  - status bit indices `ST_TX_FULL`, `ST_TX_EMPTY`, `ST_RX_NONEMPTY`, `ST_OVERFLOW`.
- One sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count/head), instantiated twice.
- Decode, latches, synchroniser and status live in `io_port_bank`.

## Test plan
- **Reset and latches:** reset for 2 cycles; write 0xA to port 0, 0x5 to port 2, 0xF to port 7.
  - Expect `gpio_out`=12'h50A.
  - Reads of ports 0 / 2 / 7 return A / 5 / F.
  - Status reads 0x2.
- **TX fill and drain:** `tx_ready`=0, push 1, 2, 3, 4, 5.
  - After 4 pushes status = 0x1.
  - After the 5th push status = 0x9 (overflow set).
  - Raise `tx_ready`: `tx_data` sequence 1, 2, 3, 4, then `tx_valid`=0.
  - Write 0x8 to port 6: overflow clears.
- **RX path:** drive `rx_data` 6, 7, 8, 9, 0xB with `rx_valid`=1.
  - `rx_ready` drops after 4 accepts; 0xB is held by the producer.
  - Reads of port 5 return 6, 7, 8, 9, then 0xB is accepted.
  - Final read returns 0xB; a further read returns 0.
- **Simultaneous events:** with the TX FIFO full, push in the same cycle as `tx_ready` pops.
  - Push is dropped; overflow is set.
  - Concurrent write of port 4 and read of port 5 both take effect.
- **Input sync and reset mid-operation:** set `gpio_in`=0x3; port 3 reads 3 after the second edge.
  - Assert reset with both FIFOs half full.
  - Next cycle `tx_valid`=0, status=0x2, `gpio_out`=0.
